// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
package bus_arbiter_pkg;

    localparam logic       RST_ENABLE = 1'b1;
    localparam int         REG_WIDTH  = 32;
    localparam int         STALL_IF   = 1;
    localparam int         STALL_MEM  = 4;
    localparam logic [3:0] SEL_WORD   = 4'hF;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IF_BUSY  = 3'd1,
        ARB_MEM_BUSY = 3'd2,
        ARB_IF_HOLD  = 3'd3,
        ARB_MEM_HOLD = 3'd4
    } arb_state_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// 8-bit clearable wait counter; o_expire flags the TIMEOUT-th unacknowledged cycle.
module arb_timeout_cnt
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expire = i_inc && (r_count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Shares one Wishbone-classic bus between instruction fetch and data access,
// stalling each pipeline stage until its own transfer has completed.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = REG_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [5:0]        stall_ctrl,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stall_req_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_req_mem,
    output logic              bus_cyc,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_timeout
);

    arb_state_e        r_state;
    logic              r_bus_cyc;
    logic              r_bus_stb;
    logic              r_bus_we;
    logic [3:0]        r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_flush_pending;
    logic              r_bus_timeout;

    logic w_busy;
    logic w_start;
    logic w_expire;
    logic w_discard;
    logic w_if_done;
    logic w_mem_done;
    logic w_unused;

    assign w_busy    = (r_state == ARB_IF_BUSY) || (r_state == ARB_MEM_BUSY);
    assign w_start   = (r_state == ARB_IDLE) && !flush && (mem_req || if_req);
    assign w_discard = r_flush_pending || flush;
    assign w_unused  = &{1'b0, stall_ctrl[5], stall_ctrl[3:2], stall_ctrl[0]};

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start),
        .i_inc    (w_busy && !bus_ack),
        .o_expire (w_expire)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state         <= ARB_IDLE;
            r_bus_cyc       <= 1'b0;
            r_bus_stb       <= 1'b0;
            r_bus_we        <= 1'b0;
            r_bus_sel       <= '0;
            r_bus_addr      <= '0;
            r_bus_wdata     <= '0;
            r_if_rdata      <= '0;
            r_mem_rdata     <= '0;
            r_flush_pending <= 1'b0;
            r_bus_timeout   <= 1'b0;
        end else begin
            r_bus_timeout <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (!flush && mem_req) begin
                        r_state     <= ARB_MEM_BUSY;
                        r_bus_cyc   <= 1'b1;
                        r_bus_stb   <= 1'b1;
                        r_bus_we    <= mem_we;
                        r_bus_sel   <= mem_sel;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                    end else if (!flush && if_req) begin
                        r_state     <= ARB_IF_BUSY;
                        r_bus_cyc   <= 1'b1;
                        r_bus_stb   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_sel   <= SEL_WORD;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= '0;
                    end
                end
                ARB_IF_BUSY, ARB_MEM_BUSY: begin
                    if (bus_ack) begin
                        r_bus_cyc       <= 1'b0;
                        r_bus_stb       <= 1'b0;
                        r_flush_pending <= 1'b0;
                        if (w_discard) begin
                            r_state <= ARB_IDLE;
                        end else if (r_state == ARB_IF_BUSY) begin
                            r_if_rdata <= bus_rdata;
                            r_state    <= stall_ctrl[STALL_IF] ? ARB_IF_HOLD : ARB_IDLE;
                        end else begin
                            if (!r_bus_we) begin
                                r_mem_rdata <= bus_rdata;
                            end
                            r_state <= stall_ctrl[STALL_MEM] ? ARB_MEM_HOLD : ARB_IDLE;
                        end
                    end else if (w_expire) begin
                        r_bus_cyc       <= 1'b0;
                        r_bus_stb       <= 1'b0;
                        r_flush_pending <= 1'b0;
                        r_bus_timeout   <= 1'b1;
                        r_state         <= ARB_IDLE;
                    end else if (flush) begin
                        // The cycle in flight is finished; only its result is dropped.
                        r_flush_pending <= 1'b1;
                    end
                end
                ARB_IF_HOLD: begin
                    if (flush || !stall_ctrl[STALL_IF]) begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_MEM_HOLD: begin
                    if (flush || !stall_ctrl[STALL_MEM]) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Completion terms use bus_ack but never stall_ctrl, so no loop via the controller.
    assign w_if_done  = (r_state == ARB_IF_BUSY) && bus_ack && !r_flush_pending;
    assign w_mem_done = (r_state == ARB_MEM_BUSY) && bus_ack && !r_flush_pending;

    assign stall_req_if  = if_req && !flush && !w_if_done && (r_state != ARB_IF_HOLD);
    assign stall_req_mem = mem_req && !flush && !w_mem_done && (r_state != ARB_MEM_HOLD);

    assign if_rdata  = (w_if_done && !flush) ? bus_rdata : r_if_rdata;
    assign mem_rdata = (w_mem_done && !flush && !r_bus_we) ? bus_rdata : r_mem_rdata;

    assign bus_cyc     = r_bus_cyc;
    assign bus_stb     = r_bus_stb;
    assign bus_we      = r_bus_we;
    assign bus_sel     = r_bus_sel;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_timeout = r_bus_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, corner sequences, random transactions.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [5:0]  stall_ctrl;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        stall_req_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_req_mem;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;

    // Expected contents of the two read-data registers.
    logic [31:0] m_if;
    logic [31:0] m_mem;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          flush_at;
        logic        hold;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
    } vec_t;

    bus_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall_ctrl    (stall_ctrl),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .stall_req_if  (stall_req_if),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_sel       (mem_sel),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .stall_req_mem (stall_req_mem),
        .bus_cyc       (bus_cyc),
        .bus_stb       (bus_stb),
        .bus_we        (bus_we),
        .bus_sel       (bus_sel),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .bus_timeout   (bus_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs are driven 2 time units after the rising edge; outputs sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cyc"},       bus_cyc, 0);
        check({tag, ".stb"},       bus_stb, 0);
        check({tag, ".we"},        bus_we, 0);
        check({tag, ".sel"},       bus_sel, 0);
        check({tag, ".addr"},      bus_addr, 0);
        check({tag, ".wdata"},     bus_wdata, 0);
        check({tag, ".timeout"},   bus_timeout, 0);
        check({tag, ".stall_if"},  stall_req_if, 0);
        check({tag, ".stall_mem"}, stall_req_mem, 0);
        check({tag, ".if_rdata"},  if_rdata, 0);
        check({tag, ".mem_rdata"}, mem_rdata, 0);
    endtask

    function automatic logic [5:0] stall_word(input logic is_mem, input logic hold);
        if (is_mem) return hold ? 6'b011111 : 6'b001111;
        return hold ? 6'b000010 : 6'b111101;
    endfunction

    // One complete access from an IDLE arbiter, with the slave acking after t.delay wait cycles.
    task automatic run_txn(input vec_t t, input string tag);
        logic hold_eff;
        logic stall_x;
        hold_eff = t.hold && (t.flush_at < 0);
        step();
        if (t.is_mem) begin
            mem_req = 1'b1; mem_we = t.we; mem_sel = t.sel;
            mem_addr = t.addr; mem_wdata = t.wdata;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end
        #1;
        stall_x = t.is_mem ? stall_req_mem : stall_req_if;
        check({tag, ".req_stall"}, stall_x, 1);
        check({tag, ".req_cyc"}, bus_cyc, 0);
        for (int k = 0; k <= t.delay; k++) begin
            step();
            flush = (k == t.flush_at);
            bus_rdata = $urandom;
            if (k == t.delay) begin
                bus_ack = 1'b1;
                bus_rdata = t.rdata;
                stall_ctrl = stall_word(t.is_mem, t.hold);
            end
            #1;
            stall_x = t.is_mem ? stall_req_mem : stall_req_if;
            check({tag, ".stb"}, bus_stb, 1);
            check({tag, ".cyc"}, bus_cyc, 1);
            if (k == 0) begin
                check({tag, ".addr"}, bus_addr, t.addr);
                check({tag, ".we"}, bus_we, t.is_mem ? t.we : 1'b0);
                check({tag, ".sel"}, bus_sel, t.is_mem ? t.sel : 4'hF);
                if (t.is_mem && t.we) check({tag, ".wdata"}, bus_wdata, t.wdata);
            end
            if (k < t.delay) begin
                check({tag, ".wait_stall"}, stall_x, (k == t.flush_at) ? 0 : 1);
            end else begin
                check({tag, ".ack_stall"}, stall_x,
                      (t.flush_at >= 0 && t.flush_at < t.delay) ? 1 : 0);
                check({tag, ".ack_if_rdata"}, if_rdata, t.exp_if);
                check({tag, ".ack_mem_rdata"}, mem_rdata, t.exp_mem);
            end
        end
        step();
        bus_ack = 1'b0;
        flush = 1'b0;
        bus_rdata = $urandom;
        if (!hold_eff) begin
            if_req = 1'b0; mem_req = 1'b0; stall_ctrl = 6'b0;
        end
        #1;
        stall_x = t.is_mem ? stall_req_mem : stall_req_if;
        check({tag, ".post_cyc"}, bus_cyc, 0);
        check({tag, ".post_stb"}, bus_stb, 0);
        check({tag, ".post_timeout"}, bus_timeout, 0);
        check({tag, ".post_stall"}, stall_x, 0);
        check({tag, ".post_if_rdata"}, if_rdata, t.exp_if);
        check({tag, ".post_mem_rdata"}, mem_rdata, t.exp_mem);
        if (hold_eff) begin
            repeat (2) begin
                step();
                bus_rdata = $urandom;
                #1;
                stall_x = t.is_mem ? stall_req_mem : stall_req_if;
                check({tag, ".hold_stall"}, stall_x, 0);
                check({tag, ".hold_cyc"}, bus_cyc, 0);
                check({tag, ".hold_if_rdata"}, if_rdata, t.exp_if);
                check({tag, ".hold_mem_rdata"}, mem_rdata, t.exp_mem);
            end
            step();
            if_req = 1'b0; mem_req = 1'b0; stall_ctrl = 6'b0;
            #1;
            check({tag, ".release_cyc"}, bus_cyc, 0);
        end
    endtask

    vec_t vecs[9];
    vec_t t;
    int   n_stb;
    bit   timed_out;

    initial begin
        rst = 1'b1; flush = 1'b0; stall_ctrl = 6'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        m_if = '0; m_mem = '0;

        //            mem   we    sel       addr          wdata         rdata        dly flush hold  exp_if        exp_mem
        vecs[0] = '{1'b0, 1'b0, 4'hF,    32'h0000_0100, 32'h0,        32'h3C01_0001, 3, -1, 1'b0, 32'h3C01_0001, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 4'hF,    32'h0000_2004, 32'h0,        32'h1234_5678, 0, -1, 1'b0, 32'h3C01_0001, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 4'hF,    32'h0000_2004, 32'h0,        32'h1234_5678, 1, -1, 1'b1, 32'h3C01_0001, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 4'hF,    32'h0000_0104, 32'h0,        32'hFFFF_FFFF, 3,  1, 1'b0, 32'h3C01_0001, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 4'b0011, 32'h0000_2000, 32'hDEAD_BEEF, 32'h5555_5555, 1, -1, 1'b0, 32'h3C01_0001, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 4'hF,    32'h0000_0108, 32'h0,        32'hA5A5_0F0F, 0, -1, 1'b1, 32'hA5A5_0F0F, 32'h1234_5678};
        vecs[6] = '{1'b1, 1'b0, 4'hF,    32'h0000_3000, 32'h0,        32'h1111_1111, 2,  0, 1'b0, 32'hA5A5_0F0F, 32'h1234_5678};
        vecs[7] = '{1'b1, 1'b0, 4'b1100, 32'h0000_3004, 32'h0,        32'h8765_4321, 4, -1, 1'b1, 32'hA5A5_0F0F, 32'h8765_4321};
        vecs[8] = '{1'b0, 1'b0, 4'hF,    32'h0000_010C, 32'h0,        32'h2222_2222, 2,  2, 1'b1, 32'hA5A5_0F0F, 32'h8765_4321};

        repeat (2) step();
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end
        m_if = vecs[8].exp_if;
        m_mem = vecs[8].exp_mem;

        // Fetch and store requested together: the store owns the bus first.
        step();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_2000;
        mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
        #1;
        check("both.req_stall_if", stall_req_if, 1);
        check("both.req_stall_mem", stall_req_mem, 1);
        step(); #1;
        check("both.st_stb", bus_stb, 1);
        check("both.st_we", bus_we, 1);
        check("both.st_addr", bus_addr, 32'h0000_2000);
        check("both.st_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("both.st_sel", bus_sel, 4'b0011);
        check("both.st_stall_if", stall_req_if, 1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        #1;
        check("both.st_ack_stall_mem", stall_req_mem, 0);
        check("both.st_ack_stall_if", stall_req_if, 1);
        check("both.st_ack_mem_rdata", mem_rdata, m_mem);
        step();
        bus_ack = 1'b0; mem_req = 1'b0;
        #1;
        check("both.idle_cyc", bus_cyc, 0);
        check("both.idle_stall_if", stall_req_if, 1);
        step(); #1;
        check("both.if_stb", bus_stb, 1);
        check("both.if_addr", bus_addr, 32'h0000_0200);
        check("both.if_we", bus_we, 0);
        check("both.if_sel", bus_sel, 4'hF);
        check("both.if_stall", stall_req_if, 1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_1111;
        #1;
        check("both.if_ack_stall", stall_req_if, 0);
        check("both.if_ack_rdata", if_rdata, 32'h0000_1111);
        step();
        bus_ack = 1'b0; if_req = 1'b0;
        #1;
        m_if = 32'h0000_1111;
        check("both.if_rdata", if_rdata, m_if);
        check("both.mem_rdata", mem_rdata, m_mem);
        check("both.end_cyc", bus_cyc, 0);

        // Slave never acks: the cycle is abandoned after the timeout budget.
        step();
        if_req = 1'b1; if_addr = 32'h0000_0300;
        n_stb = 0;
        timed_out = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step(); #1;
            if (!bus_cyc) begin
                timed_out = 1'b1;
                break;
            end
            n_stb++;
        end
        if_req = 1'b0;
        check("timeout.seen", timed_out, 1);
        check("timeout.stb_cycles", n_stb, 255);
        check("timeout.pulse", bus_timeout, 1);
        check("timeout.stb_low", bus_stb, 0);
        check("timeout.if_rdata", if_rdata, m_if);
        step(); #1;
        check("timeout.pulse_end", bus_timeout, 0);
        check("timeout.cyc_low", bus_cyc, 0);

        // Random transactions against the completion model.
        for (int n = 0; n < 40; n++) begin
            t.is_mem   = 1'($urandom_range(0, 1));
            t.we       = t.is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
            t.sel      = t.is_mem ? 4'($urandom_range(1, 15)) : 4'hF;
            t.addr     = $urandom & 32'hFFFF_FFFC;
            t.wdata    = $urandom;
            t.rdata    = $urandom;
            t.delay    = $urandom_range(0, 6);
            t.flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, t.delay)) : -1;
            t.hold     = ($urandom_range(0, 2) == 0);
            if (t.flush_at < 0) begin
                if (!t.is_mem) m_if = t.rdata;
                else if (!t.we) m_mem = t.rdata;
            end
            t.exp_if  = m_if;
            t.exp_mem = m_mem;
            run_txn(t, $sformatf("rand%0d", n));
        end

        // Reset while a load is waiting for its ack.
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_4000;
        step(); #1;
        check("rstbusy.stb", bus_stb, 1);
        step();
        rst = 1'b1; mem_req = 1'b0;
        step(); #1;
        check_all_zero("rstbusy");
        rst = 1'b0;
        m_if = '0;
        m_mem = '0;

        t = '{1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1, -1, 1'b0, 32'hCAFE_F00D, 32'h0};
        run_txn(t, "after_rst");

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
